acc_cpu_control_unit: RTL and testbench

- Fetch/decode/execute sequencer for the 8-bit accumulator machine.
- Drives load/increment strobes for PC, MAR, IR and the accumulator register, ALU op select, and memory read/write.
- Memory accesses use a req/ack handshake.
- Sits between the IR opcode field / accumulator zero flag and the datapath register enables.

---
 rtl/acc_cpu_control_unit.sv | 170 +++++++++++++++++
 tb/tb_acc_cpu_control_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator machine (optional SINGLE_STEP_EN adds step/PAUSE).
// Latency: 4 cycles per memory instruction, 3 per jump, with a zero-wait memory.
// Backpressure: mem_rd/mem_we are held until mem_ack; an ack timeout leads to an absorbing ERROR state.
module acc_cpu_control_unit #(
    parameter int ACK_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [2:0] opcode,
    input  logic       ac_zero,
    input  logic       mem_ack,
    output logic       mar_sel,
    output logic       mar_load,
    output logic       mem_rd,
    output logic       mem_we,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       ac_load,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       err
);

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_JZ  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH1 = 3'd1,
        S_FETCH2 = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
`ifdef SINGLE_STEP_EN
        ,
        S_PAUSE  = 3'd7
`endif
    } state_e;

    // Where an instruction goes once it completes; IDLE always goes straight to FETCH1.
`ifdef SINGLE_STEP_EN
    localparam state_e S_RESUME = S_PAUSE;
`else
    localparam state_e S_RESUME = S_FETCH1;
`endif

    localparam bit            TO_EN   = (ACK_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            waiting;
    logic            timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        waiting   = (state_q == S_FETCH2) || (state_q == S_EXEC);
        timed_out = TO_EN && waiting && !mem_ack && (cnt_q == TO_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: begin
                if (mem_ack)        state_d = S_DECODE;
                else if (timed_out) state_d = S_ERROR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_HLT:         state_d = S_HALT;
                    OP_JMP, OP_JZ:  state_d = S_RESUME;
                    default:        state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (mem_ack)        state_d = S_RESUME;
                else if (timed_out) state_d = S_ERROR;
            end
            S_HALT:   state_d = S_HALT;
            S_ERROR:  state_d = S_ERROR;
`ifdef SINGLE_STEP_EN
            S_PAUSE:  if (step) state_d = S_FETCH1;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Counter restarts whenever a request phase is entered and counts only while it is stalled.
    always_comb begin
        cnt_d = '0;
        if (waiting && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        mar_sel  = 1'b0;
        mar_load = 1'b0;
        mem_rd   = 1'b0;
        mem_we   = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        ac_load  = 1'b0;
        alu_op   = 2'b00;
        halted   = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_FETCH1: mar_load = 1'b1;
            S_FETCH2: begin
                mem_rd  = 1'b1;
                ir_load = mem_ack;
                pc_inc  = mem_ack;
            end
            S_DECODE: begin
                case (opcode)
                    OP_HLT: ;
                    OP_JMP: pc_load = 1'b1;
                    OP_JZ:  pc_load = ac_zero;
                    default: begin
                        mar_sel  = 1'b1;
                        mar_load = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                if (opcode == OP_STA) begin
                    mem_we = 1'b1;
                end else begin
                    mem_rd  = 1'b1;
                    ac_load = mem_ack;
                    case (opcode)
                        OP_ADD:  alu_op = 2'b01;
                        OP_SUB:  alu_op = 2'b10;
                        OP_AND:  alu_op = 2'b11;
                        default: alu_op = 2'b00;
                    endcase
                end
            end
            S_HALT:   halted = 1'b1;
            S_ERROR:  err    = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_acc_cpu_control_unit.sv
// Bench for acc_cpu_control_unit: expands each instruction into its expected per-cycle strobe pattern
// and compares every cycle's outputs against it.
module tb_acc_cpu_control_unit;

    localparam int TO = 4;
`ifdef SINGLE_STEP_EN
    localparam int PN = 3;
`else
    localparam int PN = 0;
`endif

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_JZ  = 3'b111;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       ac_zero;
    logic       mem_ack;
`ifdef SINGLE_STEP_EN
    logic       step;
`endif
    logic       mar_sel, mar_load, mem_rd, mem_we, ir_load, pc_inc, pc_load, ac_load;
    logic [1:0] alu_op;
    logic       halted, err;
    logic [11:0] out_vec;

    // Output word: {mar_sel, mar_load, mem_rd, mem_we, ir_load, pc_inc, pc_load, ac_load, alu_op, halted, err}
    assign out_vec = {mar_sel, mar_load, mem_rd, mem_we, ir_load, pc_inc, pc_load, ac_load, alu_op, halted, err};

    acc_cpu_control_unit #(.ACK_TIMEOUT(TO), .TO_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef SINGLE_STEP_EN
        .step     (step),
`endif
        .opcode   (opcode),
        .ac_zero  (ac_zero),
        .mem_ack  (mem_ack),
        .mar_sel  (mar_sel),
        .mar_load (mar_load),
        .mem_rd   (mem_rd),
        .mem_we   (mem_we),
        .ir_load  (ir_load),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .ac_load  (ac_load),
        .alu_op   (alu_op),
        .halted   (halted),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        az;
        logic        ack;
        logic        stp;
        logic [1:0]  rst;   // 0 run, 1 held in reset, 2 reset dropped mid-cycle
        logic [11:0] exp;
    } cyc_t;

    cyc_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   we_cnt      = 0;

    function automatic logic [2:0] rop();
        return 3'($urandom_range(7));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1));
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s idx=%0d got=%0h want=%0h", nm, idx, got, want);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic az, input logic ack, input logic stp,
                        input logic [1:0] rst, input logic [11:0] exp);
        cyc_t c;
        c.op = op; c.az = az; c.ack = ack; c.stp = stp; c.rst = rst; c.exp = exp;
        q.push_back(c);
    endtask

    // Request phase: ack arrives after dly stalled cycles, or never within the timeout window.
    task automatic push_wait(input logic [2:0] op, input logic [11:0] base, input logic [11:0] on_ack,
                             input int dly, output bit to);
        to = 1'b1;
        for (int i = 0; i < TO; i++) begin
            if (i == dly) begin
                push(op, rbit(), 1'b1, rbit(), 2'd0, base | on_ack);
                to = 1'b0;
                break;
            end
            push(op, rbit(), 1'b0, rbit(), 2'd0, base);
        end
    endtask

    task automatic push_absorb(input logic [11:0] exp);
        for (int i = 0; i < 4; i++) push(rop(), rbit(), rbit(), 1'b1, 2'd0, exp);
    endtask

    task automatic pause_visit();
`ifdef SINGLE_STEP_EN
        push(rop(), rbit(), rbit(), 1'b0, 2'd0, 12'h000);
        push(rop(), rbit(), rbit(), 1'b0, 2'd0, 12'h000);
        push(rop(), rbit(), rbit(), 1'b1, 2'd0, 12'h000);
`endif
    endtask

    function automatic logic [11:0] exec_base(input logic [2:0] op);
        case (op)
            OP_LDA:  return 12'h200;
            OP_STA:  return 12'h100;
            OP_ADD:  return 12'h204;
            OP_SUB:  return 12'h208;
            OP_AND:  return 12'h20C;
            default: return 12'h000;
        endcase
    endfunction

    task automatic add_instr(input logic [2:0] op, input int fd, input int ed, input logic az);
        bit to;
        push(rop(), rbit(), rbit(), rbit(), 2'd0, 12'h400);
        push_wait(rop(), 12'h200, 12'h0C0, fd, to);
        if (to) begin
            push_absorb(12'h001);
            return;
        end
        case (op)
            OP_HLT: begin
                push(op, rbit(), rbit(), rbit(), 2'd0, 12'h000);
                push_absorb(12'h002);
            end
            OP_JMP: begin
                push(op, rbit(), rbit(), rbit(), 2'd0, 12'h020);
                pause_visit();
            end
            OP_JZ: begin
                push(op, az, rbit(), rbit(), 2'd0, az ? 12'h020 : 12'h000);
                pause_visit();
            end
            default: begin
                push(op, rbit(), rbit(), rbit(), 2'd0, 12'hC00);
                push_wait(op, exec_base(op), (op == OP_STA) ? 12'h000 : 12'h010, ed, to);
                if (to) push_absorb(12'h001);
                else    pause_visit();
            end
        endcase
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) push(rop(), rbit(), rbit(), rbit(), 2'd1, 12'h000);
        push(rop(), rbit(), rbit(), rbit(), 2'd0, 12'h000);
    endtask

    task automatic add_reset_mid_add();
        push(rop(), rbit(), rbit(), rbit(), 2'd0, 12'h400);
        push(rop(), rbit(), 1'b1, rbit(), 2'd0, 12'h2C0);
        push(OP_ADD, rbit(), rbit(), rbit(), 2'd0, 12'hC00);
        push(OP_ADD, rbit(), 1'b0, rbit(), 2'd0, 12'h204);
        push(OP_ADD, rbit(), 1'b0, rbit(), 2'd2, 12'h204);
        do_reset(2);
    endtask

    initial begin
        int   n0;
        int   idx;
        cyc_t c;

        rst_n   = 1'b0;
        opcode  = 3'b000;
        ac_zero = 1'b0;
        mem_ack = 1'b0;
`ifdef SINGLE_STEP_EN
        step    = 1'b0;
`endif

        do_reset(3);
        n0 = q.size();
        add_instr(OP_LDA, 0, 0, 1'b0);
        chk("pin_lda_len",    0, 32'(q.size() - n0), 32'(4 + PN));
        chk("pin_lda_fetch1", 0, 32'(q[n0].exp),     32'h400);
        chk("pin_lda_fetch2", 0, 32'(q[n0 + 1].exp), 32'h2C0);
        chk("pin_lda_decode", 0, 32'(q[n0 + 2].exp), 32'hC00);
        chk("pin_lda_exec",   0, 32'(q[n0 + 3].exp), 32'h210);
        add_instr(OP_LDA, 0, 0, 1'b0);
        add_instr(OP_STA, 0, 3, 1'b0);
        add_instr(OP_ADD, 1, 0, 1'b0);
        add_instr(OP_SUB, 0, 3, 1'b0);
        add_instr(OP_AND, 2, 1, 1'b0);
        add_instr(OP_JZ,  0, 0, 1'b1);
        add_instr(OP_JZ,  0, 0, 1'b0);
        n0 = q.size();
        add_instr(OP_JMP, 0, 0, 1'b0);
        chk("pin_jmp_len",    0, 32'(q.size() - n0), 32'(3 + PN));
        chk("pin_jmp_decode", 0, 32'(q[n0 + 2].exp), 32'h020);
        add_instr(OP_LDA, 3, 0, 1'b0);
        n0 = q.size();
        add_instr(OP_LDA, 9, 0, 1'b0);
        chk("pin_to_len",     0, 32'(q.size() - n0), 32'd9);
        chk("pin_to_last_rd", 0, 32'(q[n0 + 4].exp), 32'h200);
        chk("pin_to_err",     0, 32'(q[n0 + 5].exp), 32'h001);
        do_reset(2);
        add_instr(OP_SUB, 0, 9, 1'b0);
        do_reset(2);
        add_instr(OP_HLT, 0, 0, 1'b0);
        do_reset(2);
        add_reset_mid_add();
        add_instr(OP_LDA, 0, 0, 1'b0);

        idx = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            opcode  = c.op;
            ac_zero = c.az;
            mem_ack = c.ack;
`ifdef SINGLE_STEP_EN
            step    = c.stp;
`endif
            rst_n   = (c.rst == 2'd1) ? 1'b0 : 1'b1;
            #1;
            chk("cycle", idx, 32'(out_vec), 32'(c.exp));
            if (out_vec[8]) we_cnt++;
            if (c.rst == 2'd2) begin
                #1 rst_n = 1'b0;
                #1 chk("async_rst", idx, 32'(out_vec), 32'h000);
            end
            idx++;
        end

        chk("sta_we_cycles", idx, 32'(we_cnt), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
